// File: rtl/note_sequencer.sv
// note_sequencer: plays a 16-entry note table (tone, note code, duration in beats)
// into the note display decoder inputs, with start/pause/stop/loop control.
// Ports: clk, rst_n (async, active-low); wr_en/wr_addr/wr_data write the table;
//   len = last step played, loop = wrap after len; start/stop are pulses, pause is a level;
//   tom/nota = current note, note_on/busy = playing or paused, step = current index,
//   done = one-cycle pulse at the end of a non-looping sequence.
module note_sequencer #(
  parameter int TICKS_PER_BEAT = 4,
  parameter int SEQ_DEPTH      = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [5:0] wr_data,
  input  logic [3:0] len,
  input  logic       loop,
  input  logic       start,
  input  logic       pause,
  input  logic       stop,
  output logic       tom,
  output logic [2:0] nota,
  output logic       note_on,
  output logic [3:0] step,
  output logic       busy,
  output logic       done
);

  localparam int TW = (TICKS_PER_BEAT > 1) ? $clog2(TICKS_PER_BEAT) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(TICKS_PER_BEAT - 1);

  typedef enum logic [1:0] {IDLE, PLAY, PAUSE} state_t;

  state_t          state, state_nxt;
  logic [5:0]      mem [SEQ_DEPTH];
  logic [TW-1:0]   tick, tick_nxt;
  logic [1:0]      beat, beat_nxt;
  logic [1:0]      dur, dur_nxt;
  logic            tom_nxt;
  logic [2:0]      nota_nxt;
  logic [3:0]      step_nxt;
  logic            done_nxt;
  logic            load;
  logic [3:0]      load_addr;
  logic            note_end;

  assign note_on  = (state != IDLE);
  assign busy     = (state != IDLE);
  assign note_end = (tick == TICK_MAX) && (beat == dur);

  // Table storage. Reads below see the pre-edge contents, so a note that
  // starts on the same edge as a write to its entry latches the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SEQ_DEPTH; i++) mem[i] <= 6'b000000;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      tick  <= '0;
      beat  <= 2'd0;
      dur   <= 2'd0;
      tom   <= 1'b0;
      nota  <= 3'd0;
      step  <= 4'd0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      tick  <= tick_nxt;
      beat  <= beat_nxt;
      dur   <= dur_nxt;
      tom   <= tom_nxt;
      nota  <= nota_nxt;
      step  <= step_nxt;
      done  <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    tick_nxt  = tick;
    beat_nxt  = beat;
    dur_nxt   = dur;
    tom_nxt   = tom;
    nota_nxt  = nota;
    step_nxt  = step;
    done_nxt  = 1'b0;
    load      = 1'b0;
    load_addr = 4'd0;

    if (stop) begin
      state_nxt = IDLE;
      tick_nxt  = '0;
      beat_nxt  = 2'd0;
      dur_nxt   = 2'd0;
      tom_nxt   = 1'b0;
      nota_nxt  = 3'd0;
      step_nxt  = 4'd0;
    end else if (start) begin
      // Restart wins over pause, from any state.
      state_nxt = PLAY;
      tick_nxt  = '0;
      beat_nxt  = 2'd0;
      step_nxt  = 4'd0;
      load      = 1'b1;
      load_addr = 4'd0;
    end else if (state != IDLE) begin
      if (pause) begin
        // Counters and outputs simply hold; the note is stretched.
        state_nxt = PAUSE;
      end else begin
        // The edge leaving PAUSE also counts, so each edge sampled with
        // pause=1 adds exactly one cycle to the note.
        state_nxt = PLAY;
        if (note_end) begin
          tick_nxt = '0;
          beat_nxt = 2'd0;
          // len below step (lowered mid-play) is treated as end of sequence.
          if (step < len) begin
            step_nxt  = step + 4'd1;
            load      = 1'b1;
            load_addr = step + 4'd1;
          end else if (loop) begin
            step_nxt  = 4'd0;
            load      = 1'b1;
            load_addr = 4'd0;
          end else begin
            state_nxt = IDLE;
            dur_nxt   = 2'd0;
            tom_nxt   = 1'b0;
            nota_nxt  = 3'd0;
            step_nxt  = 4'd0;
            done_nxt  = 1'b1;
          end
        end else if (tick == TICK_MAX) begin
          tick_nxt = '0;
          beat_nxt = beat + 2'd1;
        end else begin
          tick_nxt = tick + TW'(1);
        end
      end
    end

    if (load) begin
      dur_nxt  = mem[load_addr][5:4];
      tom_nxt  = mem[load_addr][3];
      nota_nxt = mem[load_addr][2:0];
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: directed scenarios plus randomized control/table traffic,
// checked against a note-level model (remaining-cycles count per note).
module tb_note_sequencer;
  localparam int TPB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [3:0] wr_addr = 4'd0;
  logic [5:0] wr_data = 6'd0;
  logic [3:0] len = 4'd0;
  logic       loop = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       stop = 1'b0;
  logic       tom;
  logic [2:0] nota;
  logic       note_on;
  logic [3:0] step;
  logic       busy;
  logic       done;

  note_sequencer #(.TICKS_PER_BEAT(TPB), .SEQ_DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .len(len), .loop(loop), .start(start), .pause(pause), .stop(stop),
    .tom(tom), .nota(nota), .note_on(note_on), .step(step), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [10:0] got;
  assign got = {tom, nota, note_on, step, busy, done};

  // Reference model: a note is just "this many cycles left to play".
  logic [5:0] m_mem [16];
  bit         m_act;
  logic [3:0] m_step;
  logic       m_tom;
  logic [2:0] m_nota;
  int         m_rem;
  logic       m_done;

  function automatic logic [10:0] exp_vec();
    return {m_tom, m_nota, m_act, m_step, m_act, m_done};
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 16; i++) m_mem[i] = 6'd0;
    m_act = 0; m_step = 0; m_tom = 0; m_nota = 0; m_rem = 0; m_done = 0;
  endtask

  task automatic m_latch(input logic [3:0] a);
    m_tom  = m_mem[a][3];
    m_nota = m_mem[a][2:0];
    m_rem  = (int'(m_mem[a][5:4]) + 1) * TPB;
  endtask

  task automatic m_idle();
    m_act = 0; m_step = 0; m_tom = 0; m_nota = 0; m_rem = 0;
  endtask

  task automatic m_edge();
    if (!rst_n) begin
      m_reset();
      return;
    end
    m_done = 0;
    if (stop) m_idle();
    else if (start) begin
      m_act = 1; m_step = 0; m_latch(4'd0);
    end else if (m_act && !pause) begin
      if (m_rem > 1) m_rem--;
      else if (m_step < len) begin
        m_step = m_step + 4'd1; m_latch(m_step);
      end else if (loop) begin
        m_step = 0; m_latch(4'd0);
      end else begin
        m_idle(); m_done = 1;
      end
    end
    if (wr_en) m_mem[wr_addr] = wr_data;
  endtask

  task automatic cyc();
    @(posedge clk);
    m_edge();
    @(negedge clk);
  endtask

  task automatic wr(input logic [3:0] a, input logic [5:0] d);
    wr_en = 1; wr_addr = a; wr_data = d;
    cyc();
    wr_en = 0;
  endtask

  task automatic pulse_start();
    start = 1; cyc(); start = 0;
  endtask

  task automatic test_reset();
    m_reset();
    cyc(); cyc();
    tests++;
    if (got !== 11'd0) begin fails++; $display("FAIL reset_init got=%h want=%h", got, 11'd0); end
    rst_n = 1;
    cyc();
    for (int i = 0; i < 16; i++) wr(i[3:0], 6'($urandom_range(1, 63)));
    len = 4'd3; loop = 1'b1;
    pulse_start();
    repeat (5) cyc();
    #2 rst_n = 0;
    #1;
    tests++;
    if (got !== 11'd0) begin fails++; $display("FAIL reset_async got=%h want=%h", got, 11'd0); end
    m_reset();
    @(negedge clk); rst_n = 1;
    len = 4'd15; loop = 1'b0;
    pulse_start();
    for (int c = 1; c <= 66; c++) begin
      tests++;
      if (c <= 64 && got !== {1'b0, 3'd0, 1'b1, 4'((c - 1) / 4), 1'b1, 1'b0}) begin
        fails++; $display("FAIL reset_table cyc=%0d got=%h", c, got);
      end else if (c == 65 && got !== 11'd1) begin
        fails++; $display("FAIL reset_done got=%h want=%h", got, 11'd1);
      end else if (got !== exp_vec()) begin
        fails++; $display("FAIL reset_model cyc=%0d got=%h want=%h", c, got, exp_vec());
      end
      cyc();
    end
  endtask

  task automatic test_basic();
    logic [10:0] want;
    wr(4'd0, 6'b00_0_001);
    wr(4'd1, 6'b01_1_101);
    len = 4'd1; loop = 1'b0;
    pulse_start();
    for (int c = 1; c <= 14; c++) begin
      if (c <= 4)       want = {1'b0, 3'd1, 1'b1, 4'd0, 1'b1, 1'b0};
      else if (c <= 12) want = {1'b1, 3'd5, 1'b1, 4'd1, 1'b1, 1'b0};
      else if (c == 13) want = 11'd1;
      else              want = 11'd0;
      tests++;
      if (got !== want) begin fails++; $display("FAIL basic cyc=%0d got=%h want=%h", c, got, want); end
      cyc();
    end
  endtask

  task automatic test_loop();
    loop = 1'b1;
    pulse_start();
    for (int c = 1; c <= 30; c++) begin
      tests++;
      if (c == 13 && got !== {1'b0, 3'd1, 1'b1, 4'd0, 1'b1, 1'b0}) begin
        fails++; $display("FAIL loop_wrap got=%h", got);
      end else if (got !== exp_vec()) begin
        fails++; $display("FAIL loop cyc=%0d got=%h want=%h", c, got, exp_vec());
      end
      cyc();
    end
    stop = 1; cyc(); stop = 0;
    loop = 1'b0;
  endtask

  task automatic test_pause();
    pulse_start();
    for (int c = 1; c <= 18; c++) begin
      pause = (c >= 2 && c <= 4);
      tests++;
      if (c == 7 && step !== 4'd0) begin
        fails++; $display("FAIL pause_hold step=%0d want=0", step);
      end else if (c == 8 && step !== 4'd1) begin
        fails++; $display("FAIL pause_step1 step=%0d want=1", step);
      end else if (c == 16 && done !== 1'b1) begin
        fails++; $display("FAIL pause_done done=%b want=1", done);
      end else if (got !== exp_vec()) begin
        fails++; $display("FAIL pause cyc=%0d got=%h want=%h", c, got, exp_vec());
      end
      cyc();
    end
    pause = 0;
  endtask

  task automatic test_stop();
    pulse_start();
    for (int c = 1; c <= 20; c++) begin
      stop = (c == 6);
      tests++;
      if (c == 7 && got !== 11'd0) begin
        fails++; $display("FAIL stop_idle got=%h want=0", got);
      end else if (done !== 1'b0 || got !== exp_vec()) begin
        fails++; $display("FAIL stop cyc=%0d got=%h want=%h", c, got, exp_vec());
      end
      cyc();
    end
    stop = 0;
    start = 1; stop = 1; cyc(); start = 0; stop = 0;
    tests++;
    if (got !== 11'd0) begin fails++; $display("FAIL start_stop got=%h want=0", got); end
    pulse_start();
    for (int c = 1; c <= 10; c++) begin
      start = (c == 3);
      tests++;
      if ((c == 7 && step !== 4'd0) || (c == 8 && step !== 4'd1)) begin
        fails++; $display("FAIL restart cyc=%0d step=%0d", c, step);
      end else if (got !== exp_vec()) begin
        fails++; $display("FAIL restart_model cyc=%0d got=%h want=%h", c, got, exp_vec());
      end
      cyc();
    end
    start = 0;
    stop = 1; cyc(); stop = 0;
  endtask

  task automatic test_write_hazard();
    loop = 1'b1;
    pulse_start();
    for (int c = 1; c <= 24; c++) begin
      wr_en = (c == 6); wr_addr = 4'd1; wr_data = 6'b00_0_111;
      tests++;
      if (c == 10 && nota !== 3'd5) begin
        fails++; $display("FAIL hazard_cur nota=%0d want=5", nota);
      end else if ((c == 17 || c == 20) && {step, nota} !== {4'd1, 3'd7}) begin
        fails++; $display("FAIL hazard_next cyc=%0d step=%0d nota=%0d", c, step, nota);
      end else if (c == 21 && step !== 4'd0) begin
        fails++; $display("FAIL hazard_len step=%0d want=0", step);
      end else if (got !== exp_vec()) begin
        fails++; $display("FAIL hazard cyc=%0d got=%h want=%h", c, got, exp_vec());
      end
      cyc();
    end
    wr_en = 0;
    // Write to entry 0 on the very edge that starts playback: old value plays.
    wr_en = 1; wr_addr = 4'd0; wr_data = 6'b10_1_010; start = 1;
    cyc();
    wr_en = 0; start = 0;
    tests++;
    if (nota !== 3'd1) begin fails++; $display("FAIL hazard_start nota=%0d want=1", nota); end
    stop = 1; cyc(); stop = 0;
    loop = 1'b0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      wr_en   = ($urandom_range(0, 99) < 30);
      wr_addr = 4'($urandom);
      wr_data = 6'($urandom);
      if ($urandom_range(0, 99) < 5) len = 4'($urandom);
      if ($urandom_range(0, 99) < 3) loop = ~loop;
      start = m_act ? ($urandom_range(0, 99) < 2) : ($urandom_range(0, 99) < 20);
      stop  = ($urandom_range(0, 199) < 2);
      pause = ($urandom_range(0, 99) < 12);
      cyc();
      tests++;
      if (got !== exp_vec()) begin
        fails++; $display("FAIL random cyc=%0d got=%h want=%h", c, got, exp_vec());
      end
    end
    wr_en = 0; start = 0; stop = 0; pause = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_loop();
    test_pause();
    test_stop();
    test_write_hazard();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
